// File: rtl/sfq_cap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sfq_cap_pkg
// Description : Shared types and width helpers for the SFQ output capture.
// Revision    : 1.0
// ============================================================================
package sfq_cap_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WIN  = 1'b1
    } sfq_state_e;

    // Delay counter must hold values 0..MAX_DLY inclusive.
    function automatic int dly_cnt_w(input int max_dly);
        return $clog2(max_dly + 1);
    endfunction

    // Bit counter runs 0..WIDTH-1.
    function automatic int bit_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfq_cap_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sfq_cap_fifo
// Description : Shift-register FIFO; head entry is a flop driving rd_data_o.
// Revision    : 1.0
// ============================================================================
module sfq_cap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             valid_o,
    output logic             full_o
);
    localparam int C_CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [C_CW-1:0]  cnt_q, cnt_d, wr_idx;
    logic             valid_q, full_q;
    logic             do_rd, do_wr;

    always_comb begin
        do_rd  = rd_en_i & valid_q;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        do_wr  = wr_en_i & (~full_q | do_rd);
        wr_idx = do_rd ? (cnt_q - C_CW'(1)) : cnt_q;
        mem_d  = mem_q;
        if (do_rd) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
        end
        if (do_wr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == C_CW'(i)) begin
                    mem_d[i] = wr_data_i;
                end
            end
        end
        cnt_d = cnt_q + C_CW'(do_wr) - C_CW'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            cnt_q   <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d != '0);
            full_q  <= (cnt_d == C_CW'(DEPTH));
        end
    end

    assign rd_data_o = mem_q[0];
    assign valid_o   = valid_q;
    assign full_o    = full_q;

endmodule
`default_nettype wire

// File: rtl/sfq_out_capture.sv
`default_nettype none
// ============================================================================
// Module      : sfq_out_capture
// Description : Samples SFQ inverter output windows into bits, packs words.
// Revision    : 1.0
// ============================================================================
module sfq_out_capture
    import sfq_cap_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_DLY = 4,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cell_clk,
    input  logic             cell_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             err_spurious,
    output logic             err_double,
    output logic             overflow
);
    localparam int C_DW = dly_cnt_w(MAX_DLY);
    localparam int C_BW = bit_cnt_w(WIDTH);

    sfq_state_e       state_q, state_d;
    logic [C_DW-1:0]  cnt_q, cnt_d;
    logic             hit_q, hit_d;
    logic [WIDTH-1:0] acc_q, acc_d, word;
    logic [C_BW-1:0]  bcnt_q, bcnt_d;
    logic             spur_q, spur_d, dbl_q, dbl_d, ovf_q, ovf_d;
    logic             resolve, bit_val, push, pop, fifo_full;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        acc_d   = acc_q;
        bcnt_d  = bcnt_q;
        resolve = 1'b0;
        bit_val = 1'b0;
        spur_d  = 1'b0;
        dbl_d   = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                spur_d = cell_out;
                if (cell_clk) begin
                    state_d = WIN;
                    cnt_d   = C_DW'(1);
                    hit_d   = 1'b0;
                end
            end
            WIN: begin
                // A coincident cell_out belongs to the window being closed.
                bit_val = hit_q | cell_out;
                dbl_d   = hit_q & cell_out;
                if (cell_clk) begin
                    resolve = 1'b1;
                    cnt_d   = C_DW'(1);
                    hit_d   = 1'b0;
                end else if (cnt_q == C_DW'(MAX_DLY)) begin
                    resolve = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                    hit_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + C_DW'(1);
                    hit_d = bit_val;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                hit_d   = 1'b0;
            end
        endcase
        word = {bit_val, acc_q[WIDTH-1:1]};
        if (resolve) begin
            acc_d = word;
            if (bcnt_q == C_BW'(WIDTH - 1)) begin
                bcnt_d = '0;
                push   = 1'b1;
            end else begin
                bcnt_d = bcnt_q + C_BW'(1);
            end
        end
        ovf_d = ovf_q | (push & fifo_full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            acc_q   <= '0;
            bcnt_q  <= '0;
            spur_q  <= 1'b0;
            dbl_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            acc_q   <= acc_d;
            bcnt_q  <= bcnt_d;
            spur_q  <= spur_d;
            dbl_q   <= dbl_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pop = m_valid & m_ready;

    sfq_cap_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (push),
        .wr_data_i (word),
        .rd_en_i   (m_ready),
        .rd_data_o (m_data),
        .valid_o   (m_valid),
        .full_o    (fifo_full)
    );

    assign err_spurious = spur_q;
    assign err_double   = dbl_q;
    assign overflow     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sfq_out_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfq_out_capture
// Description : Scoreboard bench with a timestamp-based window reference model.
// Revision    : 1.0
// ============================================================================
module tb_sfq_out_capture;
    localparam int W       = 8;
    localparam int MAX_DLY = 4;
    localparam int DEPTH   = 4;

    logic         clk = 1'b0, rst_n = 1'b0, cell_clk = 1'b0, cell_out = 1'b0, m_ready = 1'b0;
    logic         m_valid, err_spurious, err_double, overflow;
    logic [W-1:0] m_data;

    int total = 0, bad = 0;

    // Reference model state: windows described by the time of their opening clock.
    int           cyc = 0, last_clk = 0, hits = 0, occ = 0, exp_spur = 0, exp_dbl = 0;
    bit           have_clk = 1'b0, exp_ovf = 1'b0;
    bit           bits_q[$];
    logic [W-1:0] sb_q[$];
    int           got_spur = 0, got_dbl = 0, n_pops = 0;

    bit           ob[40];
    logic [W-1:0] w0, rb;
    int           p0;

    sfq_out_capture #(.WIDTH(W), .MAX_DLY(MAX_DLY), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cell_clk     (cell_clk),
        .cell_out     (cell_out),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .err_spurious (err_spurious),
        .err_double   (err_double),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        have_clk = 1'b0;
        hits     = 0;
        occ      = 0;
        exp_ovf  = 1'b0;
        bits_q.delete();
        sb_q.delete();
    endfunction

    function automatic void model_cycle(input bit cc, input bit co, input bit rdy);
        bit           open_w, pop, push, acc;
        logic [W-1:0] w;
        w      = '0;
        push   = 1'b0;
        open_w = have_clk && (cyc <= last_clk + MAX_DLY);
        if (co) begin
            if (open_w) begin
                hits++;
                if (hits > 1) exp_dbl++;
            end else begin
                exp_spur++;
            end
        end
        if (open_w && (cc || cyc == last_clk + MAX_DLY)) begin
            bits_q.push_back(hits > 0);
            if (bits_q.size() == W) begin
                for (int i = 0; i < W; i++) w[i] = bits_q[i];
                bits_q.delete();
                push = 1'b1;
            end
        end
        if (cc) begin
            have_clk = 1'b1;
            last_clk = cyc;
            hits     = 0;
        end
        pop = (occ > 0) && rdy;
        acc = push && ((occ < DEPTH) || pop);
        if (push && !acc) exp_ovf = 1'b1;
        if (acc) sb_q.push_back(w);
        occ = occ + int'(acc) - int'(pop);
        cyc++;
    endfunction

    task automatic step(input bit cc, input bit co);
        cell_clk = cc;
        cell_out = co;
        if (!rst_n) model_reset();
        else model_cycle(cc, co, m_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_word(input string name, input logic [W-1:0] exp);
        int n;
        n = 0;
        while (!m_valid && n < 20) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk({name, "_valid"}, 32'(m_valid), 32'd1);
        chk({name, "_data"}, 32'(m_data), 32'(exp));
        step(1'b0, 1'b0);
    endtask

    // Monitor: compares every accepted word and tallies error pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_spurious) got_spur++;
            if (err_double) got_dbl++;
            if (m_valid && m_ready) begin
                n_pops++;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL word_extra: got 0x%0h expected no word at %0t", m_data, $time);
                end else begin
                    chk("word", 32'(m_data), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        rst_n = 1'b1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_err_spurious", 32'(err_spurious), 32'd0);
        chk("rst_err_double", 32'(err_double), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Eight clocks six cycles apart, pulses after clocks 0,2,4,6.
        m_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, bit'((k % 2) == 0));
            repeat (3) step(1'b0, 1'b0);
        end
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        chk("w55_not_early", 32'(m_valid), 32'd0);
        step(1'b0, 1'b0);
        chk("w55_valid", 32'(m_valid), 32'd1);
        chk("w55_data", 32'(m_data), 32'h55);
        step(1'b0, 1'b0);

        // Window edges, double pulse, back-to-back clocks.
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("edge_in_no_spur", 32'(err_spurious), 32'd0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("edge_out_spur", 32'(err_spurious), 32'd1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("double_pulse", 32'(err_double), 32'd1);
        step(1'b0, 1'b0);
        chk("double_one_cycle", 32'(err_double), 32'd0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        wait_word("mix_word", 8'h2D);

        // Five words with the consumer stalled.
        m_ready = 1'b0;
        for (int i = 0; i < 40; i++) ob[i] = bit'($urandom_range(0, 1));
        for (int i = 0; i < W; i++) w0[i] = ob[i];
        step(1'b1, 1'b0);
        for (int i = 1; i < 40; i++) step(1'b1, ob[i-1]);
        chk("ovf_before", 32'(overflow), 32'd0);
        step(1'b0, ob[39]);
        repeat (3) step(1'b0, 1'b0);
        chk("ovf_after", 32'(overflow), 32'd1);
        chk("ovf_held_valid", 32'(m_valid), 32'd1);
        chk("ovf_head", 32'(m_data), 32'(w0));
        m_ready = 1'b1;
        p0 = n_pops;
        repeat (8) step(1'b0, 1'b0);
        chk("drain_count", 32'(n_pops - p0), 32'd4);
        chk("drain_empty", 32'(m_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-word discards the partial bits.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        chk("rst2_valid", 32'(m_valid), 32'd0);
        chk("rst2_overflow", 32'(overflow), 32'd0);
        rb = W'($urandom);
        step(1'b1, 1'b0);
        for (int i = 1; i < W; i++) step(1'b1, rb[i-1]);
        step(1'b0, rb[W-1]);
        repeat (3) step(1'b0, 1'b0);
        wait_word("post_rst_word", rb);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            m_ready = ($urandom_range(0, 99) < 60);
            step(bit'($urandom_range(0, 99) < 30), bit'($urandom_range(0, 99) < 25));
        end
        m_ready = 1'b1;
        repeat (30) step(1'b0, 1'b0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("spur_count", 32'(got_spur), 32'(exp_spur));
        chk("dbl_count", 32'(got_dbl), 32'(exp_dbl));
        chk("ovf_final", 32'(overflow), 32'(exp_ovf));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sfq_out_capture.md
# sfq_out_capture

Clocked-emulation capture stage placed directly downstream of the clocked SFQ inverter cell. It watches the cell's clock pulse and output pulse lines and decides one logic bit per cell evaluation: pulse seen after the cell clock means 1, no pulse means 0. It packs bits into WIDTH-bit words and delivers them on a valid/ready stream. It also flags spurious and double pulses and lost words.

## Interface
- WIDTH, 8, bits per output word (2..32)
- MAX_DLY, 4, last system cycle after a cell_clk pulse in which an output pulse still counts (1..15)
- DEPTH, 4, output FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- cell_clk  in  1  one-cycle pulse: cell evaluation clock (same event that drives the inverter's clk)
- cell_out  in  1  one-cycle pulse: inverter output
- m_valid  out  1  word available
- m_ready  in  1  consumer accepts word
- m_data  out  WIDTH  captured word, first-evaluated bit in bit 0
- err_spurious  out  1  one-cycle pulse: cell_out with no open window
- err_double  out  1  one-cycle pulse: second cell_out in one window
- overflow  out  1  sticky: a completed word was dropped (FIFO full)

## Operation
- States: IDLE (no window open), WIN (window open, delay counter running).
- IDLE + cell_clk → WIN, cnt=1, hit=0.
- WIN, each cycle without cell_clk: cnt increments. cell_out sets hit. If hit is already 1, err_double pulses and hit stays 1.
- Window resolves on the first of these: the cycle where cnt==MAX_DLY, or a new cell_clk. The resolved bit = hit.
- Resolution by cell_clk: the same cycle reopens a new window (cnt=1, hit=0). Resolution by cnt==MAX_DLY: → IDLE.
- cell_out in the same cycle as cell_clk while in WIN belongs to the closing window, before resolution.
- cell_out in IDLE, or with cell_clk from IDLE, pulses err_spurious and is otherwise ignored.
- Resolved bits shift into the accumulator LSB-first. A bit counter 0..WIDTH-1 wraps after WIDTH bits, and the completed word is pushed to the FIFO.
- FIFO full at push: word dropped, overflow set, bit counter still wraps. overflow stays set until reset.
- Simultaneous push and pop on a full FIFO is allowed and does not overflow.
- Reset (any cycle): state IDLE, cnt=0, hit=0, accumulator and bit counter cleared (partial word discarded), FIFO emptied.

## Timing
- Reset values: m_valid=0, m_data=0, err_spurious=0, err_double=0, overflow=0.
- A cell_clk at cycle t opens the window for cycles t+1..t+MAX_DLY. cell_out in those cycles yields bit 1.
- The bit resolves at cycle t+MAX_DLY, or earlier at the next cell_clk.
- Word latency: m_valid rises in the cycle after the last bit resolves. m_data is registered.
- Transfer occurs on m_valid & m_ready. m_data and m_valid hold stable while m_ready=0.
- err_* pulses are registered and appear one cycle after the offending cell_out.
- Throughput: one bit per cell_clk, with a minimum cell_clk spacing of 1 cycle.

## Structure
- Package sfq_cap_pkg holds:
  - the state enum (IDLE, WIN)
  - the widths of the delay counter and bit counter, derived via $clog2
- Sub-module sfq_cap_fifo: synchronous WIDTH×DEPTH FIFO with registered outputs, synchronous active-low reset, and full/empty flags.
- The top level holds the window FSM, accumulator, error logic and overflow flag.

## Test plan
- WIDTH=8, MAX_DLY=4. Eight cell_clk pulses 6 cycles apart, with cell_out 2 cycles after clocks 0,2,4,6 → one word m_data=0x55, m_valid one cycle after the 8th window closes (cycle t8+4+1).
- Window edge: cell_out at exactly t+4 → bit 1. cell_out at t+5 → err_spurious pulse and bit 0.
- Two cell_out pulses at t+1 and t+3 → err_double at t+4, bit 1. Back-to-back cell_clk with cell_out coincident on the second → the pulse counts for the first window.
- m_ready=0 throughout, 5 words completed with DEPTH=4:
  - first 4 words are held
  - overflow=1 after the 5th word
  - releasing m_ready drains exactly 4 words in order
- Reset asserted after 3 bits: m_valid=0, overflow=0. The next 8 bits form a clean word with no contribution from the discarded bits.
- Random cell_clk/cell_out/m_ready traffic against a scoreboard model → every accepted word matches, and error pulse counts match.
